// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Issue/retire stage in front of a combinational ALU. It accepts one command
//   at a time over a valid/ready handshake and registers the operands and
//   opcode that drive the ALU. After one evaluation cycle it captures the ALU
//   result and flags into an output register, which is presented downstream
//   over valid/ready. It also keeps an accumulator and a carry flag. The carry
//   flag drives the ALU carry input, and the accumulator can replace operand A,
//   so multi-byte add-with-carry chains need no help from the host.
//
// Ports
//   i_clk, i_rst         clock; synchronous active-high reset
//   i_cmd_valid          command present
//   o_cmd_ready          command accepted this cycle
//   i_cmd_opcode         ALU opcode (1 ADD, 2 ADC, 3 SUB, 4 INC, 5 DEC,
//                        6 AND, 7 NOT, 8 ROL, 9 ROR)
//   i_cmd_a, i_cmd_b     operands (A is ignored when i_cmd_use_acc=1)
//   i_cmd_use_acc        take operand A from the accumulator
//   o_alu_a, o_alu_b     registered ALU operands
//   o_alu_opcode         registered ALU opcode, 0 while idle
//   o_alu_car_in         ALU carry input (the architectural carry flag)
//   i_alu_*              ALU result and status flags
//   o_res_valid          result register holds an unconsumed result
//   i_res_ready          downstream takes the result
//   o_res_y, o_res_flags captured result and {invalid,parity,zero,borrow,carry}
//   o_acc_out            accumulator
//   o_carry_flag         architectural carry/borrow flag
//   o_ops_retired        count of valid ops retired, saturating
module alu_op_sequencer #(
  parameter int BUS_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [3:0]           i_cmd_opcode,
  input  logic [BUS_WIDTH-1:0] i_cmd_a,
  input  logic [BUS_WIDTH-1:0] i_cmd_b,
  input  logic                 i_cmd_use_acc,
  output logic [BUS_WIDTH-1:0] o_alu_a,
  output logic [BUS_WIDTH-1:0] o_alu_b,
  output logic [3:0]           o_alu_opcode,
  output logic                 o_alu_car_in,
  input  logic [BUS_WIDTH-1:0] i_alu_y,
  input  logic                 i_alu_car_out,
  input  logic                 i_alu_borrow,
  input  logic                 i_alu_zero,
  input  logic                 i_alu_parity,
  input  logic                 i_alu_invalid_op,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic [BUS_WIDTH-1:0] o_res_y,
  output logic [4:0]           o_res_flags,
  output logic [BUS_WIDTH-1:0] o_acc_out,
  output logic                 o_carry_flag,
  output logic [CNT_WIDTH-1:0] o_ops_retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_INC = 4'd4;
  localparam logic [3:0] OP_DEC = 4'd5;

  state_t               r_state;
  logic [BUS_WIDTH-1:0] r_alu_a;
  logic [BUS_WIDTH-1:0] r_alu_b;
  logic [3:0]           r_alu_opcode;
  logic                 r_res_valid;
  logic [BUS_WIDTH-1:0] r_res_y;
  logic [4:0]           r_res_flags;
  logic [BUS_WIDTH-1:0] r_acc;
  logic                 r_carry;
  logic [CNT_WIDTH-1:0] r_ops;

  logic                 w_cmd_ready;
  logic                 w_accept;

  // In HOLD a new command may enter only in the cycle the held result retires.
  assign w_cmd_ready = (r_state == IDLE) || ((r_state == HOLD) && i_res_ready);
  assign w_accept    = w_cmd_ready && i_cmd_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_opcode <= '0;
      r_res_valid  <= 1'b0;
      r_res_y      <= '0;
      r_res_flags  <= '0;
      r_acc        <= '0;
      r_carry      <= 1'b0;
      r_ops        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_alu_a      <= i_cmd_use_acc ? r_acc : i_cmd_a;
            r_alu_b      <= i_cmd_b;
            r_alu_opcode <= i_cmd_opcode;
            r_state      <= EXEC;
          end
        end

        EXEC: begin
          r_res_y     <= i_alu_y;
          r_res_flags <= {i_alu_invalid_op, i_alu_parity, i_alu_zero,
                          i_alu_borrow, i_alu_car_out};
          r_res_valid <= 1'b1;
          // An invalid opcode still produces a result but leaves no trace in
          // the architectural state.
          if (!i_alu_invalid_op) begin
            r_acc <= i_alu_y;
            if ((r_alu_opcode == OP_ADD) || (r_alu_opcode == OP_ADC) ||
                (r_alu_opcode == OP_INC)) begin
              r_carry <= i_alu_car_out;
            end else if ((r_alu_opcode == OP_SUB) || (r_alu_opcode == OP_DEC)) begin
              r_carry <= i_alu_borrow;
            end
            if (r_ops != {CNT_WIDTH{1'b1}}) begin
              r_ops <= r_ops + 1'b1;
            end
          end
          r_state <= HOLD;
        end

        HOLD: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            // The accumulator was already updated at the end of EXEC, so a
            // back-to-back use_acc command sees the previous result here.
            if (i_cmd_valid) begin
              r_alu_a      <= i_cmd_use_acc ? r_acc : i_cmd_a;
              r_alu_b      <= i_cmd_b;
              r_alu_opcode <= i_cmd_opcode;
              r_state      <= EXEC;
            end else begin
              r_alu_opcode <= '0;
              r_state      <= IDLE;
            end
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready   = w_cmd_ready;
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_opcode  = r_alu_opcode;
  assign o_alu_car_in  = r_carry;
  assign o_res_valid   = r_res_valid;
  assign o_res_y       = r_res_y;
  assign o_res_flags   = r_res_flags;
  assign o_acc_out     = r_acc;
  assign o_carry_flag  = r_carry;
  assign o_ops_retired = r_ops;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: a small behavioural ALU closes the loop and
// each task drives a directed scenario against hand-computed values. The
// retired-op counter is narrowed to 4 bits so saturation is reachable quickly.
module tb_alu_op_sequencer;

  localparam int BW = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_opcode;
  logic [BW-1:0] cmd_a;
  logic [BW-1:0] cmd_b;
  logic          cmd_use_acc;
  logic [BW-1:0] alu_a;
  logic [BW-1:0] alu_b;
  logic [3:0]    alu_opcode;
  logic          alu_car_in;
  logic [BW-1:0] alu_y;
  logic          alu_car_out;
  logic          alu_borrow;
  logic          alu_zero;
  logic          alu_parity;
  logic          alu_invalid_op;
  logic          res_valid;
  logic          res_ready;
  logic [BW-1:0] res_y;
  logic [4:0]    res_flags;
  logic [BW-1:0] acc_out;
  logic          carry_flag;
  logic [CW-1:0] ops_retired;

  int total = 0;
  int bad   = 0;

  alu_op_sequencer #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_cmd_valid      (cmd_valid),
    .o_cmd_ready      (cmd_ready),
    .i_cmd_opcode     (cmd_opcode),
    .i_cmd_a          (cmd_a),
    .i_cmd_b          (cmd_b),
    .i_cmd_use_acc    (cmd_use_acc),
    .o_alu_a          (alu_a),
    .o_alu_b          (alu_b),
    .o_alu_opcode     (alu_opcode),
    .o_alu_car_in     (alu_car_in),
    .i_alu_y          (alu_y),
    .i_alu_car_out    (alu_car_out),
    .i_alu_borrow     (alu_borrow),
    .i_alu_zero       (alu_zero),
    .i_alu_parity     (alu_parity),
    .i_alu_invalid_op (alu_invalid_op),
    .o_res_valid      (res_valid),
    .i_res_ready      (res_ready),
    .o_res_y          (res_y),
    .o_res_flags      (res_flags),
    .o_acc_out        (acc_out),
    .o_carry_flag     (carry_flag),
    .o_ops_retired    (ops_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational ALU the sequencer drives.
  logic [BW:0] aluWide;
  always_comb begin
    aluWide        = '0;
    alu_borrow     = 1'b0;
    alu_invalid_op = 1'b0;
    case (alu_opcode)
      4'd1: aluWide = {1'b0, alu_a} + {1'b0, alu_b};
      4'd2: aluWide = {1'b0, alu_a} + {1'b0, alu_b} + {{BW{1'b0}}, alu_car_in};
      4'd3: begin aluWide = {1'b0, alu_a - alu_b}; alu_borrow = (alu_a < alu_b); end
      4'd4: aluWide = {1'b0, alu_a} + 1'b1;
      4'd5: begin aluWide = {1'b0, alu_a - 1'b1}; alu_borrow = (alu_a == '0); end
      4'd6: aluWide = {1'b0, alu_a & alu_b};
      4'd7: aluWide = {1'b0, ~alu_a};
      4'd8: aluWide = {1'b0, alu_a[BW-2:0], alu_a[BW-1]};
      4'd9: aluWide = {1'b0, alu_a[0], alu_a[BW-1:1]};
      default: alu_invalid_op = 1'b1;
    endcase
    alu_y       = aluWide[BW-1:0];
    alu_car_out = aluWide[BW];
    alu_zero    = (alu_y == '0);
    alu_parity  = ^alu_y;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [3:0] op, input logic [BW-1:0] a,
                           input logic [BW-1:0] b, input logic useAcc);
    cmd_valid   = 1'b1;
    cmd_opcode  = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = useAcc;
  endtask

  task automatic idle_cmd();
    cmd_valid   = 1'b0;
    cmd_opcode  = 4'd0;
    cmd_a       = '0;
    cmd_b       = '0;
    cmd_use_acc = 1'b0;
  endtask

  // Issue from IDLE and run through EXEC so the result sits in HOLD.
  task automatic run_op(input logic [3:0] op, input logic [BW-1:0] a,
                        input logic [BW-1:0] b, input logic useAcc);
    drive_cmd(op, a, b, useAcc);
    step();
    idle_cmd();
    step();
  endtask

  task automatic retire();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_cmd();
    res_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    total++;
    if ({cmd_ready, res_valid, alu_opcode, res_y, res_flags, acc_out, carry_flag, ops_retired, alu_a, alu_b}
        !== {1'b1, 1'b0, 4'd0, 8'h00, 5'd0, 8'h00, 1'b0, 4'd0, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL reset_state: ready=%b rv=%b op=%h y=%h fl=%b acc=%h cf=%b ops=%0d (want ready=1 rest 0)",
               cmd_ready, res_valid, alu_opcode, res_y, res_flags, acc_out, carry_flag, ops_retired);
    end
  endtask

  task automatic test_add_latency();
    drive_cmd(4'd1, 8'hF0, 8'h20, 1'b0);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL add_ready_idle: got %b want 1", cmd_ready); end
    step();
    idle_cmd();
    total++;
    if ({alu_a, alu_b, alu_opcode, res_valid, cmd_ready} !== {8'hF0, 8'h20, 4'd1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL add_exec: a=%h b=%h op=%h rv=%b rdy=%b want F0 20 1 0 0", alu_a, alu_b, alu_opcode, res_valid, cmd_ready);
    end
    step();
    total++;
    if ({res_valid, res_y, res_flags} !== {1'b1, 8'h10, 5'b01001}) begin
      bad++;
      $display("FAIL add_result: rv=%b y=%h fl=%b want 1 10 01001", res_valid, res_y, res_flags);
    end
    total++;
    if ({acc_out, carry_flag, ops_retired} !== {8'h10, 1'b1, 4'd1}) begin
      bad++;
      $display("FAIL add_arch: acc=%h cf=%b ops=%0d want 10 1 1", acc_out, carry_flag, ops_retired);
    end
    retire();
    total++;
    if ({res_valid, alu_opcode, cmd_ready} !== {1'b0, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL add_retire_idle: rv=%b op=%h rdy=%b want 0 0 1", res_valid, alu_opcode, cmd_ready);
    end
  endtask

  task automatic test_adc_acc();
    drive_cmd(4'd2, 8'h77, 8'h01, 1'b1);
    step();
    idle_cmd();
    total++;
    if ({alu_a, alu_b, alu_car_in} !== {8'h10, 8'h01, 1'b1}) begin
      bad++;
      $display("FAIL adc_operands: a=%h b=%h cin=%b want 10 01 1", alu_a, alu_b, alu_car_in);
    end
    step();
    total++;
    if ({res_y, res_flags, acc_out, carry_flag, ops_retired} !== {8'h12, 5'b00000, 8'h12, 1'b0, 4'd2}) begin
      bad++;
      $display("FAIL adc_result: y=%h fl=%b acc=%h cf=%b ops=%0d want 12 00000 12 0 2",
               res_y, res_flags, acc_out, carry_flag, ops_retired);
    end
    retire();
  endtask

  task automatic test_sub_and();
    run_op(4'd3, 8'h05, 8'h07, 1'b0);
    total++;
    if ({res_y, res_flags, carry_flag, acc_out} !== {8'hFE, 5'b01010, 1'b1, 8'hFE}) begin
      bad++;
      $display("FAIL sub_result: y=%h fl=%b cf=%b acc=%h want FE 01010 1 FE", res_y, res_flags, carry_flag, acc_out);
    end
    retire();
    run_op(4'd6, 8'hFF, 8'h0F, 1'b0);
    total++;
    if ({res_y, res_flags, carry_flag, acc_out, ops_retired} !== {8'h0F, 5'b00000, 1'b1, 8'h0F, 4'd4}) begin
      bad++;
      $display("FAIL and_keeps_carry: y=%h fl=%b cf=%b acc=%h ops=%0d want 0F 00000 1 0F 4",
               res_y, res_flags, carry_flag, acc_out, ops_retired);
    end
    retire();
  endtask

  task automatic test_invalid();
    run_op(4'd0, 8'hAA, 8'h55, 1'b0);
    total++;
    if ({res_valid, res_y, res_flags} !== {1'b1, 8'h00, 5'b10100}) begin
      bad++;
      $display("FAIL invalid_result: rv=%b y=%h fl=%b want 1 00 10100", res_valid, res_y, res_flags);
    end
    total++;
    if ({acc_out, carry_flag, ops_retired} !== {8'h0F, 1'b1, 4'd4}) begin
      bad++;
      $display("FAIL invalid_no_update: acc=%h cf=%b ops=%0d want 0F 1 4", acc_out, carry_flag, ops_retired);
    end
    retire();
  endtask

  task automatic test_back_to_back();
    run_op(4'd1, 8'h01, 8'h02, 1'b0);
    drive_cmd(4'd5, 8'h99, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({res_valid, res_y, res_flags, cmd_ready} !== {1'b1, 8'h03, 5'b00000, 1'b0}) begin
        bad++;
        $display("FAIL hold_stable[%0d]: rv=%b y=%h fl=%b rdy=%b want 1 03 00000 0", i, res_valid, res_y, res_flags, cmd_ready);
      end
      step();
    end
    res_ready = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL hold_ready_follows: got %b want 1", cmd_ready); end
    step();
    res_ready = 1'b0;
    idle_cmd();
    total++;
    if ({alu_a, alu_opcode, res_valid} !== {8'h03, 4'd5, 1'b0}) begin
      bad++;
      $display("FAIL b2b_accept: a=%h op=%h rv=%b want 03 5 0", alu_a, alu_opcode, res_valid);
    end
    step();
    total++;
    if ({res_y, res_flags, carry_flag, ops_retired} !== {8'h02, 5'b01000, 1'b0, 4'd6}) begin
      bad++;
      $display("FAIL b2b_result: y=%h fl=%b cf=%b ops=%0d want 02 01000 0 6", res_y, res_flags, carry_flag, ops_retired);
    end
    retire();
  endtask

  task automatic test_dec_not_boundary();
    run_op(4'd5, 8'h00, 8'h00, 1'b0);
    total++;
    if ({res_y, res_flags, carry_flag, ops_retired} !== {8'hFF, 5'b00010, 1'b1, 4'd7}) begin
      bad++;
      $display("FAIL dec_wrap: y=%h fl=%b cf=%b ops=%0d want FF 00010 1 7", res_y, res_flags, carry_flag, ops_retired);
    end
    retire();
    run_op(4'd7, 8'h0F, 8'h00, 1'b0);
    total++;
    if ({res_y, carry_flag, acc_out} !== {8'hF0, 1'b1, 8'hF0}) begin
      bad++;
      $display("FAIL not_keeps_carry: y=%h cf=%b acc=%h want F0 1 F0", res_y, carry_flag, acc_out);
    end
    retire();
    run_op(4'd8, 8'h81, 8'h00, 1'b0);
    total++;
    if ({res_y, carry_flag} !== {8'h03, 1'b1}) begin
      bad++;
      $display("FAIL rol_keeps_carry: y=%h cf=%b want 03 1", res_y, carry_flag);
    end
    retire();
  endtask

  task automatic test_saturation();
    // Counter is at 9; eight more INCs would reach 17, so it must pin at 15.
    for (int i = 0; i < 8; i++) begin
      run_op(4'd4, 8'hFF, 8'h00, 1'b0);
      retire();
    end
    total++;
    if ({ops_retired, carry_flag, acc_out} !== {4'd15, 1'b1, 8'h00}) begin
      bad++;
      $display("FAIL ops_saturate: ops=%0d cf=%b acc=%h want 15 1 00", ops_retired, carry_flag, acc_out);
    end
  endtask

  task automatic test_reset_exec();
    drive_cmd(4'd1, 8'h12, 8'h34, 1'b0);
    step();
    idle_cmd();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({cmd_ready, res_valid, acc_out, carry_flag, ops_retired, alu_opcode} !== {1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0}) begin
      bad++;
      $display("FAIL reset_in_exec: rdy=%b rv=%b acc=%h cf=%b ops=%0d op=%h want 1 0 00 0 0 0",
               cmd_ready, res_valid, acc_out, carry_flag, ops_retired, alu_opcode);
    end
    step();
    total++;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_stays_idle: rv=%b want 0", res_valid); end
  endtask

  initial begin
    rst = 1'b1;
    res_ready = 1'b0;
    idle_cmd();
    test_reset();
    test_add_latency();
    test_adc_acc();
    test_sub_and();
    test_invalid();
    test_back_to_back();
    test_dec_not_boundary();
    test_saturation();
    test_reset_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
